// File: rtl/spi_arb_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | spi_arb_pkg : shared types and defaults for the SPI host arbiter       |
// | Rev 1.0                                                                |
// +------------------------------------------------------------------------+
package spi_arb_pkg;

  localparam int NUM_REQ_DEFAULT        = 4;
  localparam int IDX_W                  = $clog2(NUM_REQ_DEFAULT);
  localparam int GAP_CYCLES_DEFAULT     = 4;
  localparam int TIMEOUT_CYCLES_DEFAULT = 1024;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_RESP  = 3'd3,
    ST_GAP   = 3'd4
  } arb_state_e;

endpackage
`default_nettype wire

// File: rtl/spi_host_arbiter_rr.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | rr_arbiter : combinational round-robin pick, first set bit from i_ptr  |
// | Rev 1.0                                                                |
// +------------------------------------------------------------------------+
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_ptr,
  output logic [NUM_REQ-1:0] o_gnt,
  output logic [IDX_W-1:0]   o_idx,
  output logic               o_any
);

  logic [IDX_W-1:0] w_cand;
  logic             w_found;

  always_comb begin
    o_gnt   = '0;
    o_idx   = '0;
    w_found = 1'b0;
    w_cand  = '0;
    // Walk the candidates in rotation order; the first hit wins.
    for (int k = 0; k < NUM_REQ; k++) begin
      w_cand = IDX_W'((int'(i_ptr) + k) % NUM_REQ);
      if (!w_found && i_req[w_cand]) begin
        w_found       = 1'b1;
        o_idx         = w_cand;
        o_gnt[w_cand] = 1'b1;
      end
    end
  end

  assign o_any = w_found;

endmodule
`default_nettype wire

// File: rtl/spi_host_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | spi_host_arbiter : round-robin sequencer sharing one SPI host among     |
// | NUM_REQ requesters. Optional WAIT watchdog: SPI_ARB_TIMEOUT_EN.  Rev 1.0|
// +------------------------------------------------------------------------+
module spi_host_arbiter
  import spi_arb_pkg::*;
#(
  parameter int NUM_REQ        = NUM_REQ_DEFAULT,
  parameter int DATA_WIDTH     = 16,
  parameter int GAP_CYCLES     = GAP_CYCLES_DEFAULT,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            i_req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_data,
  output logic [NUM_REQ-1:0]            o_gnt,
  output logic [NUM_REQ-1:0]            o_rsp_valid,
  output logic [DATA_WIDTH-1:0]         o_rsp_data,
  output logic                          o_rsp_err,
  output logic [NUM_REQ-1:0]            o_cs_sel,
  output logic                          o_busy,
  output logic                          o_host_tx_start,
  output logic [DATA_WIDTH-1:0]         o_host_tx_data,
  input  logic                          i_host_tx_done,
  input  logic                          i_host_rx_valid,
  input  logic [DATA_WIDTH-1:0]         i_host_rx_data
);

  localparam int c_IDX_W = $clog2(NUM_REQ);
  localparam int c_GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  arb_state_e              r_state;
  logic [c_IDX_W-1:0]      r_ptr;
  logic [NUM_REQ-1:0]      r_gnt;
  logic [NUM_REQ-1:0]      r_rsp_valid;
  logic [DATA_WIDTH-1:0]   r_rsp_data;
  logic                    r_busy;
  logic                    r_tx_start;
  logic [DATA_WIDTH-1:0]   r_tx_data;
  logic [c_GAP_W-1:0]      r_gap_cnt;

  logic [NUM_REQ-1:0]      w_pick_oh;
  logic [c_IDX_W-1:0]      w_pick_idx;
  logic                    w_pick_any;
  logic                    w_unused_rx_valid;

  // The host raises rx_valid together with tx_done, so tx_done alone qualifies rx_data.
  assign w_unused_rx_valid = i_host_rx_valid;

`ifdef SPI_ARB_TIMEOUT_EN
  localparam int c_TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [c_TO_W-1:0]       r_to_cnt;
  logic                    r_rsp_err;
`endif

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (c_IDX_W)
  ) u_rr (
    .i_req (i_req),
    .i_ptr (r_ptr),
    .o_gnt (w_pick_oh),
    .o_idx (w_pick_idx),
    .o_any (w_pick_any)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_ptr       <= '0;
      r_gnt       <= '0;
      r_rsp_valid <= '0;
      r_rsp_data  <= '0;
      r_busy      <= 1'b0;
      r_tx_start  <= 1'b0;
      r_tx_data   <= '0;
      r_gap_cnt   <= '0;
`ifdef SPI_ARB_TIMEOUT_EN
      r_to_cnt    <= '0;
      r_rsp_err   <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_pick_any) begin
            r_gnt      <= w_pick_oh;
            r_tx_data  <= i_req_data[w_pick_idx*DATA_WIDTH +: DATA_WIDTH];
            r_tx_start <= 1'b1;
            r_busy     <= 1'b1;
            r_ptr      <= (w_pick_idx == c_IDX_W'(NUM_REQ - 1)) ? '0 : w_pick_idx + 1'b1;
            r_state    <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          r_tx_start <= 1'b0;
`ifdef SPI_ARB_TIMEOUT_EN
          r_to_cnt   <= '0;
`endif
          r_state    <= ST_WAIT;
        end
        ST_WAIT: begin
          if (i_host_tx_done) begin
            r_rsp_data  <= i_host_rx_data;
            r_rsp_valid <= r_gnt;
`ifdef SPI_ARB_TIMEOUT_EN
            r_rsp_err   <= 1'b0;
`endif
            r_state     <= ST_RESP;
          end
`ifdef SPI_ARB_TIMEOUT_EN
          else if (r_to_cnt == c_TO_W'(TIMEOUT_CYCLES - 1)) begin
            r_rsp_data  <= '0;
            r_rsp_valid <= r_gnt;
            r_rsp_err   <= 1'b1;
            r_state     <= ST_RESP;
          end else begin
            r_to_cnt <= r_to_cnt + 1'b1;
          end
`endif
        end
        ST_RESP: begin
          r_rsp_valid <= '0;
          r_gnt       <= '0;
`ifdef SPI_ARB_TIMEOUT_EN
          r_rsp_err   <= 1'b0;
`endif
          if (GAP_CYCLES > 0) begin
            r_gap_cnt <= '0;
            r_state   <= ST_GAP;
          end else begin
            r_busy    <= 1'b0;
            r_state   <= ST_IDLE;
          end
        end
        ST_GAP: begin
          if (r_gap_cnt == c_GAP_W'(GAP_CYCLES - 1)) begin
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end else begin
            r_gap_cnt <= r_gap_cnt + 1'b1;
          end
        end
        default: begin
          r_gnt      <= '0;
          r_busy     <= 1'b0;
          r_tx_start <= 1'b0;
          r_state    <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_gnt           = r_gnt;
  assign o_cs_sel        = r_gnt;
  assign o_rsp_valid     = r_rsp_valid;
  assign o_rsp_data      = r_rsp_data;
  assign o_busy          = r_busy;
  assign o_host_tx_start = r_tx_start;
  assign o_host_tx_data  = r_tx_data;
`ifdef SPI_ARB_TIMEOUT_EN
  assign o_rsp_err       = r_rsp_err;
`else
  assign o_rsp_err       = 1'b0;
`endif

endmodule
`default_nettype wire

// File: doc/spi_host_arbiter.md
Name: spi_host_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one SPI host among NUM_REQ requesters.
- Latches the winning requester's word, pulses the host's tx_start and waits for tx_done.
- Returns rx_data to the winner, then enforces an inter-frame gap.
- Drives a one-hot cs_sel so the top level routes the host's spi_cs_n to the winner's slave.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_WIDTH, 16, SPI word width; matches the host
GAP_CYCLES, 4, idle clocks between frames (0 = no gap)
TIMEOUT_CYCLES, 1024, watchdog limit in WAIT (used only with the optional feature)

Ports:
clk  in  1  system clock
rst_n  in  1  reset; one clock; reset is asynchronous and active-low
req  in  NUM_REQ  level request per requester
req_data  in  NUM_REQ*DATA_WIDTH  tx words; requester i occupies slice [i*DATA_WIDTH +: DATA_WIDTH]
gnt  out  NUM_REQ  one-hot grant; high from ISSUE through RESP
rsp_valid  out  NUM_REQ  one-cycle one-hot response strobe
rsp_data  out  DATA_WIDTH  received word; valid with rsp_valid
rsp_err  out  1  timeout flag; valid with rsp_valid
cs_sel  out  NUM_REQ  one-hot slave select; equals gnt
busy  out  1  high whenever state is not IDLE
host_tx_start  out  1  one-cycle start pulse to the SPI host
host_tx_data  out  DATA_WIDTH  latched word to the host
host_tx_done  in  1  host frame-complete pulse
host_rx_valid  in  1  host rx valid pulse
host_rx_data  in  DATA_WIDTH  host received word

Behaviour:
- Reset (async, rst_n=0) clears:
  - outputs gnt, rsp_valid, rsp_data, rsp_err, cs_sel, busy, host_tx_start, host_tx_data to 0;
  - internal state to IDLE, rr_ptr to 0, counters to 0.
- Reset mid-frame: the arbiter drops everything immediately; no response is issued. The host shares rst and resets with it.
- FSM states: IDLE, ISSUE, WAIT, RESP, GAP.
- IDLE:
  - If any req is set, pick the first set bit searching from rr_ptr upward, wrapping modulo NUM_REQ.
  - Register the winner index and latch its slice into host_tx_data.
  - Next state ISSUE.
  - rr_ptr <= winner+1, wrapping to 0 after NUM_REQ-1.
- ISSUE (1 cycle): gnt/cs_sel assert; host_tx_start=1 for exactly this cycle. Next state WAIT.
- WAIT:
  - Hold gnt and cs_sel.
  - On host_tx_done=1, capture host_rx_data into rsp_data. Next state RESP.
  - host_rx_valid is not required; the host raises it together with tx_done.
- RESP (1 cycle):
  - rsp_valid[winner]=1 and rsp_err=0.
  - gnt drops at the end of this cycle.
  - Next state GAP if GAP_CYCLES>0, else IDLE.
- GAP: count GAP_CYCLES clocks with all grants low, then go to IDLE.
- Latency: req set in IDLE -> host_tx_start 2 clocks later (IDLE sample, ISSUE drive).
  - host_tx_done -> rsp_valid 1 clock later.
  - Back-to-back frames from a single requester: start-to-start spacing is frame length + 3 + GAP_CYCLES clocks.
- Requester handshake:
  - A requester holds req high until its rsp_valid.
  - req_data is sampled only at grant; later changes are ignored.
  - Dropping req after grant does not abort the frame; the response strobe still fires.
  - A requester still holding req after rsp_valid is eligible again, and the rotation gives others priority first.
- Simultaneous requests: the lowest index at or above rr_ptr wins. No requester waits more than NUM_REQ-1 frames.
- A host_tx_done seen outside WAIT is ignored.

Optional Feature:
- Macro SPI_ARB_TIMEOUT_EN.
- When defined:
  - A counter of width $clog2(TIMEOUT_CYCLES+1) runs in WAIT, cleared on entry.
  - On reaching TIMEOUT_CYCLES without host_tx_done, go to RESP with rsp_data=0 and rsp_err=1, then GAP as normal.
  - A late host_tx_done arriving after this is ignored.
- When undefined: WAIT has no bound, rsp_err is tied 0 and no counter exists.

Decomposition:
- Package spi_arb_pkg holds:
  - the state enum (IDLE, ISSUE, WAIT, RESP, GAP);
  - localparam IDX_W = $clog2(NUM_REQ);
  - the default GAP and TIMEOUT constants.
- One sub-module, rr_arbiter (combinational one-hot pick from req and rr_ptr), is natural and reusable. The FSM, counters and datapath stay in the top module.

Test Plan:
- Single frame: req=4'b0010, slice1=16'hA5C3, host returns 16'h3C5A after 40 clks.
  - Expect host_tx_start 2 clks after req.
  - Expect gnt=cs_sel=4'b0010.
  - Expect rsp_valid=4'b0010 with rsp_data=16'h3C5A 1 clk after tx_done, then a 4-clk GAP.
- Contention: req=4'b1111 held throughout, with distinct words 16'h1111..16'h4444.
  - Expect grant order 0,1,2,3,0.
  - Expect each host_tx_data equal to the matching slice.
- Fairness after pointer move: complete a frame for requester 2, then set req=4'b0101.
  - Expect requester 0 granted first (pointer=3 wraps to 0), then requester 2.
- Withdraw and data change: after grant to requester 3, drop req and change req_data.
  - Expect the frame still completes with the original word and rsp_valid[3] fires once.
- Reset mid-WAIT: pull rst_n low asynchronously.
  - Expect all outputs 0 immediately and no rsp_valid.
  - After release with req=4'b0001, expect a normal frame to requester 0.
- With SPI_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=16: never assert host_tx_done.
  - Expect rsp_valid, rsp_err=1 and rsp_data=0 after 16 WAIT clocks, then the arbiter returns to IDLE.
